// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its RAM array.
package dmem_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CNT_W  = 16;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } dmem_state_t;

endpackage : dmem_pkg

// File: rtl/data_mem_responder_if.sv
// Load/store port between the memory access stage (master) and the data memory (slave).
interface data_mem_responder_if #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) ();

    logic              ena;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic [DATA_W-1:0] douta;
    logic              busy;

    modport master (
        output ena, wea, addra, dina,
        input  douta, busy
    );

    modport slave (
        input  ena, wea, addra, dina,
        output douta, busy
    );

endinterface : data_mem_responder_if

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-first: a read that coincides with a write
// to the same address returns the word as it was before that write.
module dmem_array #(
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int DATA_W = dmem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Sampling mem before the edge commits the write is what makes this read-first.
    always_comb begin
        rdata_d = rd_en ? mem[addr] : rdata_q;
    end

    // NOTE: the storage array has no reset so it maps onto block RAM; clearing it
    // is the job of the sweep in the parent, only the output register is reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// Data-memory responder: init sweep FSM, access decode, optional second read
// stage, saturating debug counters and a sticky access-during-init flag.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int                         ADDR_W       = dmem_pkg::ADDR_W,
    parameter int                         DATA_W       = dmem_pkg::DATA_W,
    parameter int                         READ_LATENCY = 1,
    parameter logic [dmem_pkg::DATA_W-1:0] INIT_VALUE  = '0
) (
    input  logic                  clka,
    input  logic                  rsta,
    data_mem_responder_if.slave   bus,
    output logic [CNT_W-1:0]      rd_count,
    output logic [CNT_W-1:0]      wr_count,
    output logic                  access_err
);

    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    dmem_state_t       state_q,    state_d;
    logic [ADDR_W-1:0] ptr_q,      ptr_d;
    logic              busy_q,     busy_d;
    logic              err_q,      err_d;
    logic [CNT_W-1:0]  rd_cnt_q,   rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q,   wr_cnt_d;

    logic              mem_we;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data;

    // NOTE: every signal gets a default at the top of the block so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        busy_d    = busy_q;
        err_d     = err_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        mem_we    = 1'b0;
        mem_rd_en = 1'b0;
        mem_addr  = bus.addra;
        mem_wdata = bus.dina;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = INIT_VALUE;
                ptr_d     = ptr_q + 1'b1;
                if (bus.ena) begin
                    err_d = 1'b1;
                end
                if (ptr_q == PTR_LAST) begin
                    state_d = READY;
                    busy_d  = 1'b0;
                end
            end
            READY: begin
                if (bus.ena) begin
                    mem_rd_en = 1'b1;
                    if (bus.wea) begin
                        mem_we = 1'b1;
                        if (wr_cnt_q != '1) begin
                            wr_cnt_d = wr_cnt_q + 1'b1;
                        end
                    end else if (rd_cnt_q != '1) begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q  <= INIT;
            ptr_q    <= '0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clka),
        .rst   (rsta),
        .rd_en (mem_rd_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (rd_data)
    );

    // With two cycles of latency the RAM output register acts as stage 1 and
    // douta only reloads when that stage holds a fresh result.
    if (READ_LATENCY == 2) begin : g_lat2
        logic              s1_vld_q, s1_vld_d;
        logic [DATA_W-1:0] douta_q,  douta_d;

        always_comb begin
            s1_vld_d = mem_rd_en;
            douta_d  = s1_vld_q ? rd_data : douta_q;
        end

        always_ff @(posedge clka) begin
            if (rsta) begin
                s1_vld_q <= 1'b0;
                douta_q  <= '0;
            end else begin
                s1_vld_q <= s1_vld_d;
                douta_q  <= douta_d;
            end
        end

        assign bus.douta = douta_q;
    end else begin : g_lat1
        assign bus.douta = rd_data;
    end

    assign bus.busy   = busy_q;
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;
    assign access_err = err_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: two responders (read latency 1 and 2) driven in lockstep
// and compared every edge against a transaction-level memory model.
module tb_data_mem_responder;

    localparam logic [31:0] INIT_V = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rsta = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(7), .DATA_W(32)) bus1 ();
    data_mem_responder_if #(.ADDR_W(7), .DATA_W(32)) bus2 ();

    logic [15:0] rd_count1, wr_count1, rd_count2, wr_count2;
    logic        err1, err2;

    data_mem_responder #(
        .READ_LATENCY (1),
        .INIT_VALUE   (INIT_V)
    ) dut_l1 (
        .clka       (clk),
        .rsta       (rsta),
        .bus        (bus1),
        .rd_count   (rd_count1),
        .wr_count   (wr_count1),
        .access_err (err1)
    );

    data_mem_responder #(
        .READ_LATENCY (2),
        .INIT_VALUE   (INIT_V)
    ) dut_l2 (
        .clka       (clk),
        .rsta       (rsta),
        .bus        (bus2),
        .rd_count   (rd_count2),
        .wr_count   (wr_count2),
        .access_err (err2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: memory contents, remaining sweep edges, and the results
    // each latency variant should present.
    logic [31:0] m_mem [128];
    int          m_sweep = 0;
    int          m_rd    = 0;
    int          m_wr    = 0;
    bit          m_err   = 1'b0;
    logic [31:0] m_d1    = '0;
    logic [31:0] m_d2    = '0;
    logic [31:0] m_pend  = '0;
    bit          m_pend_v = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit e, input bit w, input int a, input logic [31:0] d);
        bus1.ena   = e;
        bus1.wea   = w;
        bus1.addra = 7'(a);
        bus1.dina  = d;
        bus2.ena   = e;
        bus2.wea   = w;
        bus2.addra = 7'(a);
        bus2.dina  = d;
    endtask

    task automatic model_edge();
        logic [31:0] next_d2;
        if (rsta) begin
            for (int i = 0; i < 128; i++) m_mem[i] = INIT_V;
            m_sweep  = 128;
            m_rd     = 0;
            m_wr     = 0;
            m_err    = 1'b0;
            m_d1     = '0;
            m_d2     = '0;
            m_pend_v = 1'b0;
        end else begin
            next_d2  = m_pend_v ? m_pend : m_d2;
            m_pend_v = 1'b0;
            if (m_sweep > 0) begin
                if (bus1.ena) m_err = 1'b1;
                m_sweep--;
            end else if (bus1.ena) begin
                m_d1     = m_mem[bus1.addra];
                m_pend   = m_mem[bus1.addra];
                m_pend_v = 1'b1;
                if (bus1.wea) begin
                    m_mem[bus1.addra] = bus1.dina;
                    if (m_wr < 65535) m_wr++;
                end else begin
                    if (m_rd < 65535) m_rd++;
                end
            end
            m_d2 = next_d2;
        end
    endtask

    task automatic compare_all();
        check("busy_l1",   32'(bus1.busy), 32'(m_sweep > 0));
        check("busy_l2",   32'(bus2.busy), 32'(m_sweep > 0));
        check("douta_l1",  bus1.douta, m_d1);
        check("douta_l2",  bus2.douta, m_d2);
        check("rd_cnt_l1", 32'(rd_count1), 32'(m_rd));
        check("wr_cnt_l1", 32'(wr_count1), 32'(m_wr));
        check("rd_cnt_l2", 32'(rd_count2), 32'(m_rd));
        check("wr_cnt_l2", 32'(wr_count2), 32'(m_wr));
        check("err_l1",    32'(err1), 32'(m_err));
        check("err_l2",    32'(err2), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rsta = 1'b1;
        drive(0, 0, 0, '0);
        tick();
        rsta = 1'b0;
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (bus1.busy === 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        if (bus1.busy !== 1'b0) check("ready_timeout", 32'(bus1.busy), 32'd0);
    endtask

    // Counts the samples with busy high, starting with the one right after reset.
    task automatic count_busy(output int hi);
        int guard = 0;
        hi = (bus1.busy === 1'b1) ? 1 : 0;
        while (bus1.busy === 1'b1 && guard < 400) begin
            tick();
            guard++;
            if (bus1.busy === 1'b1) hi++;
        end
    endtask

    initial begin
        int hi;
        drive(0, 0, 0, '0);

        // Init sweep length and contents.
        do_reset();
        count_busy(hi);
        check("busy_edges", 32'(hi), 32'd128);
        drive(1, 0, 0, '0);
        tick();
        check("init_rd0", bus1.douta, INIT_V);
        drive(1, 0, 64, '0);
        tick();
        check("init_rd64", bus1.douta, INIT_V);
        drive(1, 0, 127, '0);
        tick();
        check("init_rd127", bus1.douta, INIT_V);
        drive(0, 0, 0, '0);
        tick();
        check("init_rd127_l2", bus2.douta, INIT_V);

        // Write then read of the same word on the next cycle.
        do_reset();
        wait_ready();
        drive(1, 1, 5, 32'h12345678);
        tick();
        drive(1, 0, 5, '0);
        tick();
        check("wr_rd_l1", bus1.douta, 32'h12345678);
        drive(0, 0, 0, '0);
        tick();
        check("wr_rd_l2", bus2.douta, 32'h12345678);
        check("wr_rd_wr_cnt", 32'(wr_count1), 32'd1);
        check("wr_rd_rd_cnt", 32'(rd_count1), 32'd1);

        // Read-first on a write.
        drive(1, 1, 9, 32'hA);
        tick();
        drive(1, 1, 9, 32'hB);
        tick();
        check("rf_old_l1", bus1.douta, 32'hA);
        drive(1, 0, 9, '0);
        tick();
        check("rf_new_l1", bus1.douta, 32'hB);
        check("rf_old_l2", bus2.douta, 32'hA);
        drive(0, 0, 0, '0);
        tick();
        check("rf_new_l2", bus2.douta, 32'hB);
        tick();
        check("idle_hold_l1", bus1.douta, 32'hB);

        // Access during the sweep is dropped and flagged.
        do_reset();
        repeat (9) tick();
        drive(1, 1, 3, 32'hFF);
        tick();
        drive(0, 0, 0, '0);
        wait_ready();
        check("init_acc_err", 32'(err1), 32'd1);
        check("init_acc_wr", 32'(wr_count1), 32'd0);
        drive(1, 0, 3, '0);
        tick();
        check("init_acc_rd", bus1.douta, INIT_V);
        drive(0, 0, 0, '0);
        tick();

        // Reset in the middle of a sweep restarts it and clears the flag.
        do_reset();
        repeat (19) tick();
        drive(1, 0, 0, '0);
        tick();
        drive(0, 0, 0, '0);
        repeat (29) tick();
        check("mid_err_set", 32'(err1), 32'd1);
        do_reset();
        check("mid_err_clr", 32'(err1), 32'd0);
        count_busy(hi);
        check("mid_busy_edges", 32'(hi), 32'd128);

        // Random traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom);
            tick();
        end

        // Saturation of the read counter over a filled memory.
        do_reset();
        wait_ready();
        for (int a = 0; a < 128; a++) begin
            drive(1, 1, a, $urandom);
            tick();
        end
        for (int i = 0; i < 65540; i++) begin
            drive(1, 0, $urandom_range(0, 127), '0);
            tick();
        end
        drive(0, 0, 0, '0);
        tick();
        check("rd_sat_l1", 32'(rd_count1), 32'h0000FFFF);
        check("rd_sat_l2", 32'(rd_count2), 32'h0000FFFF);
        check("wr_after_sat", 32'(wr_count1), 32'd128);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_data_mem_responder
